// File: rtl/fnd_display_sequencer_if.sv
// Handshake and display bus between a host and fnd_display_sequencer.
// The host drives value/load; the sequencer returns status and the scanned digit.
interface fnd_display_sequencer_if;
   logic [13:0] i_value;
   logic        i_load;
   logic        o_busy;
   logic        o_done;
   logic        o_overflow;
   logic [1:0]  o_digitSelect;
   logic [3:0]  o_bcd;
   logic        o_en;

   modport master (
      output i_value, i_load,
      input  o_busy, o_done, o_overflow, o_digitSelect, o_bcd, o_en
   );

   modport slave (
      input  i_value, i_load,
      output o_busy, o_done, o_overflow, o_digitSelect, o_bcd, o_en
   );
endinterface

// File: rtl/fnd_display_sequencer.sv
// Binary-to-BCD front-end for a 4-digit FND. A load starts a 14-step
// double-dabble conversion; the result replaces the display register in one
// shot. A free-running prescaler scans the digits and a combinational mux
// supplies the selected nibble plus leading-zero blanking.
module fnd_display_sequencer #(
   parameter int SCAN_DIV = 100000,
   parameter int VALUE_W  = 14
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   fnd_display_sequencer_if.slave   bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CONVERT = 2'd1;
   localparam logic [1:0] S_UPDATE  = 2'd2;

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [1:0]         state_q, state_d;
   logic [VALUE_W-1:0] bin_q;
   logic [15:0]        bcd_q;
   logic [15:0]        bcd_adj;
   logic [3:0]         cnt_q;
   logic [15:0]        disp_q;
   logic               ovf_q;
   logic               done_q;
   logic [PW-1:0]      presc_q;
   logic [1:0]         sel_q;
   logic               over_lim;
   logic [VALUE_W-1:0] clamped;

   // Values above 9999 cannot be shown on four digits; saturate them.
   assign over_lim = (bus.i_value > 14'd9999);
   assign clamped  = over_lim ? VALUE_W'(9999) : bus.i_value;

   // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < 4; k++) begin
         bcd_adj[k*4 +: 4] = (bcd_q[k*4 +: 4] >= 4'd5) ? bcd_q[k*4 +: 4] + 4'd3
                                                        : bcd_q[k*4 +: 4];
      end
   end

   // Next-state selection for the IDLE -> CONVERT -> UPDATE loop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.i_load) state_d = S_CONVERT;
         S_CONVERT: if (cnt_q == 4'd13) state_d = S_UPDATE;
         S_UPDATE:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Conversion datapath and display register; reset aborts any conversion.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.i_load) begin
                  bin_q <= clamped;
                  bcd_q <= '0;
                  cnt_q <= '0;
                  ovf_q <= over_lim;
               end
            end
            S_CONVERT: begin
               bcd_q <= {bcd_adj[14:0], bin_q[VALUE_W-1]};
               bin_q <= {bin_q[VALUE_W-2:0], 1'b0};
               cnt_q <= cnt_q + 4'd1;
            end
            S_UPDATE: begin
               disp_q <= bcd_q;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Digit scan: advance the selected digit once per SCAN_DIV clocks.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         presc_q <= '0;
         sel_q   <= 2'd0;
      end else if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_q <= '0;
         sel_q   <= sel_q + 2'd1;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   // Output mux; a digit blanks when it and every higher digit are zero.
   always_comb begin
      bus.o_bcd = disp_q[sel_q*4 +: 4];
      case (sel_q)
         2'd0:    bus.o_en = 1'b1;
         2'd1:    bus.o_en = |disp_q[15:4];
         2'd2:    bus.o_en = |disp_q[15:8];
         default: bus.o_en = |disp_q[15:12];
      endcase
   end

   assign bus.o_busy        = (state_q != S_IDLE);
   assign bus.o_done        = done_q;
   assign bus.o_overflow    = ovf_q;
   assign bus.o_digitSelect = sel_q;

endmodule

// File: tb/tb_fnd_display_sequencer.sv
// Self-checking bench for fnd_display_sequencer (SCAN_DIV = 4).
// An arithmetic model (decimal digits, cycle counts) is compared every
// negative edge; directed steps add literal expectations.
module tb_fnd_display_sequencer;

   localparam int SDIV = 4;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   fnd_display_sequencer_if bus();

   fnd_display_sequencer #(.SCAN_DIV(SDIV), .VALUE_W(14)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state
   int m_left = 0;
   int m_pend = 0;
   int m_disp = 0;
   int m_ovf  = 0;
   int m_done = 0;
   int m_cyc  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pow10(input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * 10;
      return r;
   endfunction

   // Model: a load starts a 15-cycle busy window, the clamped value appears
   // at its end; the digit index is simply elapsed cycles / SDIV mod 4.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_left = 0; m_disp = 0; m_ovf = 0; m_done = 0; m_cyc = 0;
      end else begin
         m_cyc++;
         m_done = 0;
         if (m_left == 0) begin
            if (bus.i_load === 1'b1) begin
               m_left = 15;
               m_pend = (int'(bus.i_value) > 9999) ? 9999 : int'(bus.i_value);
               m_ovf  = (int'(bus.i_value) > 9999) ? 1 : 0;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_disp = m_pend;
               m_done = 1;
            end
         end
      end
   end

   // Compare every cycle against the model.
   always @(negedge clk) begin
      int s;
      s = (m_cyc / SDIV) % 4;
      chk("busy", 32'(bus.o_busy), 32'(m_left != 0));
      chk("done", 32'(bus.o_done), 32'(m_done));
      chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
      chk("digitSelect", 32'(bus.o_digitSelect), 32'(s));
      chk("bcd", 32'(bus.o_bcd), 32'((m_disp / pow10(s)) % 10));
      chk("en", 32'(bus.o_en), 32'((s == 0) || (m_disp >= pow10(s))));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load_wait(input int v, input string nm);
      int n;
      bus.i_value = 14'(v);
      bus.i_load  = 1'b1;
      tick(1);
      bus.i_load  = 1'b0;
      chk({nm, " busy_after_load"}, 32'(bus.o_busy), 1);
      n = 0;
      while (bus.o_busy === 1'b1 && n < 40) begin
         tick(1);
         n++;
      end
      chk({nm, " busy_cycles"}, 32'(n), 15);
      chk({nm, " done_pulse"}, 32'(bus.o_done), 1);
   endtask

   task automatic scan_check(input int d, input int bcd, input int en, input string nm);
      int n = 0;
      while (int'(bus.o_digitSelect) != d && n < 40) begin
         tick(1);
         n++;
      end
      chk({nm, " scan_reached"}, 32'(n < 40), 1);
      chk({nm, " digit_bcd"}, 32'(bus.o_bcd), 32'(bcd));
      chk({nm, " digit_en"}, 32'(bus.o_en), 32'(en));
   endtask

   initial begin
      int n, dones, t0, t1;
      rst_n = 1'b1;
      bus.i_load  = 1'b0;
      bus.i_value = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst busy", 32'(bus.o_busy), 0);
      chk("rst done", 32'(bus.o_done), 0);
      chk("rst ovf", 32'(bus.o_overflow), 0);
      chk("rst sel", 32'(bus.o_digitSelect), 0);
      chk("rst bcd", 32'(bus.o_bcd), 0);
      chk("rst en", 32'(bus.o_en), 1);
      tick(2);
      rst_n = 1'b1;

      // scan sequence 0,1,2,3,0 every 4 cycles
      for (int i = 0; i < 5; i++) begin
         chk("scan step", 32'(bus.o_digitSelect), 32'(i % 4));
         tick(SDIV);
      end

      load_wait(1234, "v1234");
      scan_check(0, 4, 1, "1234 d0");
      scan_check(1, 3, 1, "1234 d1");
      scan_check(2, 2, 1, "1234 d2");
      scan_check(3, 1, 1, "1234 d3");

      load_wait(7, "v7");
      scan_check(0, 7, 1, "7 d0");
      scan_check(1, 0, 0, "7 d1");
      scan_check(2, 0, 0, "7 d2");
      scan_check(3, 0, 0, "7 d3");

      load_wait(0, "v0");
      scan_check(0, 0, 1, "0 d0");
      scan_check(1, 0, 0, "0 d1");
      scan_check(3, 0, 0, "0 d3");

      load_wait(100, "v100");
      scan_check(0, 0, 1, "100 d0");
      scan_check(1, 0, 1, "100 d1");
      scan_check(2, 1, 1, "100 d2");
      scan_check(3, 0, 0, "100 d3");

      load_wait(12000, "v12000");
      chk("12000 ovf", 32'(bus.o_overflow), 1);
      for (int d = 0; d < 4; d++) scan_check(d, 9, 1, "12000 digit");
      load_wait(9999, "v9999");
      chk("9999 ovf", 32'(bus.o_overflow), 0);
      for (int d = 0; d < 4; d++) scan_check(d, 9, 1, "9999 digit");

      // mid-cycle reset with overflow set and a non-zero display
      load_wait(16000, "v16000");
      scan_check(2, 9, 1, "pre-reset d2");
      #1 rst_n = 1'b0;
      #1;
      chk("midrst busy", 32'(bus.o_busy), 0);
      chk("midrst ovf", 32'(bus.o_overflow), 0);
      chk("midrst sel", 32'(bus.o_digitSelect), 0);
      chk("midrst bcd", 32'(bus.o_bcd), 0);
      chk("midrst en", 32'(bus.o_en), 1);
      tick(2);
      rst_n = 1'b1;

      // load 42, then a stray load pulse during busy cycles 3..10
      bus.i_value = 14'd42;
      bus.i_load  = 1'b1;
      tick(1);
      bus.i_load  = 1'b0;
      tick(2);
      bus.i_value = 14'd55;
      bus.i_load  = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (bus.o_done === 1'b1) dones++;
      end
      bus.i_load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (bus.o_done === 1'b1) dones++;
      end
      chk("ignore single done", 32'(dones), 1);
      scan_check(0, 2, 1, "42 d0");
      scan_check(1, 4, 1, "42 d1");
      scan_check(2, 0, 0, "42 d2");

      // load held high: done pulses 16 cycles apart
      bus.i_value = 14'd5;
      bus.i_load  = 1'b1;
      t0 = -1; t1 = -1; n = 0;
      while (t1 < 0 && n < 60) begin
         tick(1);
         n++;
         if (bus.o_done === 1'b1) begin
            if (t0 < 0) t0 = n; else t1 = n;
         end
      end
      chk("held load period", 32'(t1 - t0), 16);
      bus.i_load = 1'b0;
      n = 0;
      while (bus.o_busy === 1'b1 && n < 20) begin tick(1); n++; end
      chk("held load drained", 32'(bus.o_busy), 0);

      // reset during conversion: display back to 0000, no done
      bus.i_value = 14'd5678;
      bus.i_load  = 1'b1;
      tick(1);
      bus.i_load  = 1'b0;
      tick(7);
      #1 rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(bus.o_busy), 0);
      chk("abort done", 32'(bus.o_done), 0);
      chk("abort bcd", 32'(bus.o_bcd), 0);
      tick(2);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (bus.o_done === 1'b1) dones++;
      end
      chk("abort no done", 32'(dones), 0);
      scan_check(1, 0, 0, "abort d1");
      load_wait(31, "v31");
      scan_check(0, 1, 1, "31 d0");
      scan_check(1, 3, 1, "31 d1");
      scan_check(2, 0, 0, "31 d2");

      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: got running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fnd_display_sequencer.md
Name: fnd_display_sequencer

Overview:
- Sequential front-end that drives the 4-digit FND path (BCD-to-FND decoder) from a binary result value.
- On a load strobe it converts a 14-bit binary value to 4 BCD digits using a multi-cycle shift-add-3 (double-dabble) FSM and latches them into a display register.
- It continuously scans the four digits with a prescaled tick and supplies the digit select, the current BCD nibble and the enable (leading-zero blanking) to the decoder.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit-scan step (1 ms at 100 MHz); must be >= 2.
- VALUE_W, 14, width of the binary input; fixed at 14 (max 16383).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_value  input  14  binary value to display; sampled only on an accepted load.
- i_load  input  1  load strobe; level-sampled in IDLE.
- o_busy  output  1  high while a conversion is in progress.
- o_done  output  1  one-cycle pulse when the display register updates.
- o_overflow  output  1  registered; set when the last accepted value was >9999.
- o_digitSelect  output  2  current scanned digit; 0 = ones (rightmost), 3 = thousands.
- o_bcd  output  4  BCD nibble of the selected digit.
- o_en  output  1  digit enable; 0 = blank (leading zero).

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; o_busy=0, o_done=0, o_overflow=0.
  - Display register = 0000; prescaler=0; o_digitSelect=0; o_bcd=0; o_en=1.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE:
  - If i_load=1 at an edge (E0), latch the value and go to CONVERT; o_busy=1 after E0.
  - Latched value is min(i_value, 9999). o_overflow is registered at E0 as (i_value>9999).
- CONVERT:
  - Runs exactly 14 cycles (edges E1..E14), one shift per edge.
  - On each shift, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1.
  - Uses a 4-bit iteration counter; go to UPDATE when count = 13.
- UPDATE (edge E15):
  - Copy the scratch BCD into the display register atomically.
  - o_done=1 for the cycle after E15; o_busy=0 after E15; return to IDLE.
- Load-to-display latency: 15 edges after E0. o_busy is high for exactly 15 cycles.
- While busy, i_load is ignored (no queuing) and i_value is don't-care. The display register keeps its old value until UPDATE, so there are no partial digits.
- A load held high continuously starts a new conversion on the first IDLE cycle after UPDATE, i.e. back-to-back conversions every 16 cycles.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - At the terminal count, o_digitSelect increments mod 4 (3 wraps to 0).
  - Scanning is independent of the FSM and runs during conversion.
- Output mux (combinational from the registered o_digitSelect and the display register):
  - o_bcd = selected nibble.
  - Blanking: o_en=0 when the selected digit and all higher digits are zero. Digit 0 is never blanked, so value 0 shows "0".
- Reset mid-conversion: abort immediately to reset values. The display reverts to 0000 and no o_done is produced.

Test Plan:
- Reset with SCAN_DIV=4: hold i_reset_n=0 mid-cycle -> all outputs at reset values immediately. Then o_digitSelect steps 0,1,2,3,0 every 4 cycles after release.
- Load 1234 -> o_busy high for 15 cycles; o_done pulses one cycle after E15. Scan yields (sel,bcd,en) = (0,4,1), (1,3,1), (2,2,1), (3,1,1).
- Load 7 -> digits show 7,0,0,0 with o_en = 1,0,0,0. Load 0 -> digit 0 shows 0 with en=1, others blanked. Load 100 -> digits show 0,0,1,0 with o_en = 1,1,1,0.
- Load 12000 -> display 9,9,9,9 and o_overflow=1. A following load of 9999 -> 9999 and o_overflow=0.
- Load 42, then pulse i_load with i_value=55 during cycles 3..10 of busy -> pulse ignored; final display 42; single o_done. With i_load held high, conversions restart every 16 cycles.
- Load 5678; assert reset at CONVERT cycle 7 -> display 0000, no o_done. After release, load 31 -> display 31 with correct latency.
